// File: rtl/enemy_wave_scheduler.sv
// Enemy wave scheduler: generates the shared speed tick, issues one-hot spawn strobes to free
// enemy slots after LFSR-randomised gaps, latches a random sprite address per spawned slot and
// shortens the speed period after every completed wave.
module enemy_wave_scheduler #(
   parameter int unsigned N_ENEMIES        = 4,
   parameter int unsigned ADDRESSWIDTH     = 10,
   parameter int unsigned ADR_ENEMY_A      = 0,
   parameter int unsigned ADR_ENEMY_B      = 64,
   parameter int unsigned DIV_WIDTH        = 24,
   parameter int unsigned SPEED_DIV_START  = 2000000,
   parameter int unsigned SPEED_DIV_MIN    = 250000,
   parameter int unsigned SPEED_STEP       = 250000,
   parameter int unsigned GAP_MIN          = 8,
   parameter logic [7:0]  GAP_MASK         = 8'h1F,
   parameter int unsigned ENEMIES_PER_WAVE = 6,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              en_i,
   input  logic                              restart_i,
   input  logic [N_ENEMIES-1:0]              enemy_active_i,
   output logic                              speed_pulse_o,
   output logic [N_ENEMIES-1:0]              spawn_pulse_o,
   output logic [N_ENEMIES*ADDRESSWIDTH-1:0] adr_enemy_start_o,
   output logic [7:0]                        wave_o
);

   localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
   localparam logic [15:0] LfsrTaps = 16'hB400;

   localparam logic [DIV_WIDTH-1:0] PeriodStart = DIV_WIDTH'(SPEED_DIV_START);
   localparam logic [DIV_WIDTH-1:0] PeriodMin   = DIV_WIDTH'(SPEED_DIV_MIN);
   localparam logic [DIV_WIDTH-1:0] DivOne      = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH:0]   PeriodStep  = (DIV_WIDTH + 1)'(SPEED_STEP);
   // Smallest period that can still take a full step without dropping below the floor
   localparam logic [DIV_WIDTH:0]   StepFloor   = (DIV_WIDTH + 1)'(SPEED_DIV_MIN) + PeriodStep;

   localparam logic [ADDRESSWIDTH-1:0] AdrA = ADDRESSWIDTH'(ADR_ENEMY_A);
   localparam logic [ADDRESSWIDTH-1:0] AdrB = ADDRESSWIDTH'(ADR_ENEMY_B);

   localparam int unsigned      SpawnW      = $clog2(ENEMIES_PER_WAVE + 2);
   localparam logic [SpawnW-1:0] SpawnTarget = SpawnW'(ENEMIES_PER_WAVE);
   localparam logic [SpawnW-1:0] SpawnOne    = SpawnW'(1);
   localparam int unsigned      SlotW       = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;

   localparam logic [8:0] GapMin = 9'(GAP_MIN);
   localparam logic [8:0] GapOne = 9'd1;

   typedef enum logic [2:0] {
      StIdle,
      StGap,
      StPick,
      StSpawn,
      StDrain,
      StNextWave
   } state_e;

   state_e                                   state_q;
   logic [15:0]                              lfsr_q, lfsr_d;
   logic [DIV_WIDTH-1:0]                     div_cnt_q;
   logic [DIV_WIDTH-1:0]                     period_q;
   logic [DIV_WIDTH-1:0]                     period_stepped;
   logic                                     speed_pulse_q;
   logic [N_ENEMIES-1:0]                     spawn_pulse_q;
   logic [7:0]                               wave_q;
   logic [SpawnW-1:0]                        spawned_q;
   logic [8:0]                               gap_q;
   logic [8:0]                               gap_reload;
   logic [N_ENEMIES-1:0][1:0]                pending_q;
   logic [N_ENEMIES-1:0][ADDRESSWIDTH-1:0]   adr_q;
   logic                                     tick;
   logic [N_ENEMIES-1:0]                     free_slot;
   logic                                     pick_found;
   logic [SlotW-1:0]                         pick_idx;
   logic [N_ENEMIES-1:0]                     pick_onehot;

   // Divider expiry this cycle; becomes the registered speed pulse on the next edge
   assign tick       = en_i && (div_cnt_q == '0);
   assign gap_reload = GapMin + {1'b0, lfsr_q[7:0] & GAP_MASK};

   // LFSR next state: advances only while the game runs
   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
      end
   end

   // LFSR state; deliberately untouched by restart so successive games differ
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= SeedEff;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Next period after a completed wave, clamped at the floor without underflow
   always_comb begin
      if ({1'b0, period_q} >= StepFloor) begin
         period_stepped = DIV_WIDTH'({1'b0, period_q} - PeriodStep);
      end else begin
         period_stepped = PeriodMin;
      end
   end

   // Speed divider: counts down, pulses for one cycle at zero and reloads the current period
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt_q     <= PeriodStart - DivOne;
         speed_pulse_q <= 1'b0;
      end else if (restart_i) begin
         div_cnt_q     <= PeriodStart - DivOne;
         speed_pulse_q <= 1'b0;
      end else if (en_i) begin
         if (div_cnt_q == '0) begin
            div_cnt_q     <= period_q - DivOne;
            speed_pulse_q <= 1'b1;
         end else begin
            div_cnt_q     <= div_cnt_q - DivOne;
            speed_pulse_q <= 1'b0;
         end
      end else begin
         speed_pulse_q <= 1'b0;
      end
   end

   // Slot availability and lowest-index free slot selection
   always_comb begin
      pick_found  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      for (int i = 0; i < int'(N_ENEMIES); i++) begin
         free_slot[i] = !enemy_active_i[i] && (pending_q[i] == 2'd0);
      end
      for (int i = int'(N_ENEMIES) - 1; i >= 0; i--) begin
         if (free_slot[i]) begin
            pick_found     = 1'b1;
            pick_idx       = SlotW'(i);
            pick_onehot    = '0;
            pick_onehot[i] = 1'b1;
         end
      end
   end

   // Spawn FSM with pending counters, address latches, wave count and period
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         spawn_pulse_q <= '0;
         wave_q        <= '0;
         period_q      <= PeriodStart;
         spawned_q     <= '0;
         gap_q         <= '0;
         pending_q     <= '0;
         adr_q         <= {N_ENEMIES{AdrA}};
      end else if (restart_i) begin
         state_q       <= StIdle;
         spawn_pulse_q <= '0;
         wave_q        <= '0;
         period_q      <= PeriodStart;
         spawned_q     <= '0;
         gap_q         <= '0;
         pending_q     <= '0;
         adr_q         <= {N_ENEMIES{AdrA}};
      end else if (!en_i) begin
         // Pause: everything except the FSM position is kept; resume starts a fresh gap
         state_q       <= StIdle;
         spawn_pulse_q <= '0;
      end else begin
         spawn_pulse_q <= '0;
         // Pending covers the enemy_control start-up latency and slots that never go active
         for (int i = 0; i < int'(N_ENEMIES); i++) begin
            if (enemy_active_i[i]) begin
               pending_q[i] <= 2'd0;
            end else if (pending_q[i] != 2'd0) begin
               pending_q[i] <= pending_q[i] - 2'd1;
            end
         end
         unique case (state_q)
            StIdle: begin
               gap_q   <= gap_reload;
               state_q <= StGap;
            end
            StGap: begin
               if (gap_q == '0) begin
                  state_q <= StPick;
               end else if (tick) begin
                  gap_q <= gap_q - GapOne;
                  if (gap_q == GapOne) begin
                     state_q <= StPick;
                  end
               end
            end
            StPick: begin
               if (pick_found) begin
                  adr_q[pick_idx]     <= lfsr_q[0] ? AdrB : AdrA;
                  spawn_pulse_q       <= pick_onehot;
                  pending_q[pick_idx] <= 2'd3;
                  spawned_q           <= spawned_q + SpawnOne;
                  state_q             <= StSpawn;
               end
            end
            StSpawn: begin
               if (spawned_q >= SpawnTarget) begin
                  state_q <= StDrain;
               end else begin
                  gap_q   <= gap_reload;
                  state_q <= StGap;
               end
            end
            StDrain: begin
               if ((enemy_active_i == '0) && (pending_q == '0)) begin
                  state_q <= StNextWave;
               end
            end
            StNextWave: begin
               if (wave_q != 8'hFF) begin
                  wave_q <= wave_q + 8'd1;
               end
               period_q  <= period_stepped;
               spawned_q <= '0;
               gap_q     <= gap_reload;
               state_q   <= StGap;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign speed_pulse_o     = speed_pulse_q;
   assign spawn_pulse_o     = spawn_pulse_q;
   assign adr_enemy_start_o = adr_q;
   assign wave_o            = wave_q;

endmodule

// File: doc/enemy_wave_scheduler.md
Name: enemy_wave_scheduler

Overview:
Upstream sequencer for a bank of N enemy_control instances. It generates the shared speed_pulse timebase and issues one-hot spawn_pulse strobes to free enemy slots, separated by LFSR-randomised gaps. Each spawned slot gets a latched, randomly chosen sprite start address. Enemies are grouped into waves, and each completed wave shortens the speed period down to a floor.

Parameters:
N_ENEMIES, 4, number of enemy_control slots driven
ADDRESSWIDTH, 10, sprite ROM address width (matches enemy_control)
ADR_ENEMY_A, 0, sprite start address, enemy type A
ADR_ENEMY_B, 64, sprite start address, enemy type B
DIV_WIDTH, 24, width of speed divider
SPEED_DIV_START, 2000000, initial speed_pulse period in clk cycles
SPEED_DIV_MIN, 250000, lowest allowed period
SPEED_STEP, 250000, period decrement per completed wave
GAP_MIN, 8, minimum inter-spawn gap in speed_pulses
GAP_MASK, 8'h1F, mask applied to LFSR for the random gap part
ENEMIES_PER_WAVE, 6, spawns per wave
LFSR_SEED, 16'hACE1, LFSR reset value (0 is replaced by 16'h0001)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  game running; low = pause
restart  in  1  synchronous single-cycle new-game clear
enemy_active  in  N_ENEMIES  spawn outputs of the enemy_control slots
speed_pulse  out  1  single-cycle movement tick to all enemies
spawn_pulse  out  N_ENEMIES  one-hot single-cycle spawn strobe
adr_enemy_start  out  N_ENEMIES*ADDRESSWIDTH  per-slot sprite address; slot i occupies bits [i*AW +: AW]
wave  out  8  current wave number, starts at 0

Behaviour:
- Reset (rst_n low, async) values:
  - state=IDLE, speed_pulse=0, spawn_pulse=0, wave=0
  - all adr_enemy_start slots = ADR_ENEMY_A
  - period=SPEED_DIV_START, div_cnt=SPEED_DIV_START-1
  - spawned=0, pending=0, lfsr=LFSR_SEED
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clk while en=1. Never reaches 0.
- Divider: while en=1, div_cnt decrements each clk. When div_cnt==0, speed_pulse=1 for that cycle and div_cnt reloads period-1. Resulting pulse period = period clks. en=0 holds div_cnt and forces speed_pulse=0.
- speed_pulse and spawn_pulse are registered outputs.
- Slot free(i) = !enemy_active[i] && pending[i]==0.
- pending[i] is a 2-bit down-counter:
  - loaded with 3 when slot i is spawned;
  - decrements each clk;
  - cleared early when enemy_active[i]=1.
  - This covers the 2-cycle enemy_control latency and slots stuck in GONE.
- FSM:
  - IDLE: when en=1, load gap = GAP_MIN + (lfsr[7:0] & GAP_MASK), go to GAP.
  - GAP: gap decrements on each speed_pulse. At gap==0, go to PICK.
  - PICK: choose the lowest-index free slot. Latch that slot's address = lfsr[0] ? ADR_ENEMY_B : ADR_ENEMY_A. Go to SPAWN. If no slot is free, stay in PICK (no timeout).
  - SPAWN: spawn_pulse[slot]=1 for exactly one cycle; pending[slot]=3; spawned++.
    - If spawned reaches ENEMIES_PER_WAVE, go to DRAIN.
    - Otherwise reload a new random gap and go to GAP.
  - DRAIN: when enemy_active==0 and all pending==0, go to NEXT_WAVE.
  - NEXT_WAVE (one cycle):
    - wave = wave+1, saturating at 255.
    - period = max(SPEED_DIV_MIN, period-SPEED_STEP), computed without underflow.
    - spawned=0, reload gap, go to GAP.
    - A new period takes effect at the next div_cnt reload.
- en=0 in any state: go to IDLE next cycle. No spawn_pulse is issued. wave, period, spawned, pending and addresses are retained (pause). Resume restarts with a fresh gap.
- restart=1 (synchronous): restores all reset values except lfsr, which keeps running. restart has priority over every other event in the same cycle.
- Simultaneous speed_pulse and gap reaching 0: the transition to PICK occurs; at most one spawn per SPAWN visit.
- adr_enemy_start for a slot changes only in the PICK→SPAWN cycle for that slot.
- Async reset asserted mid-SPAWN: spawn_pulse drops immediately.

Test Plan:
- Reset, then en=1 with SPEED_DIV_START=10 → speed_pulse every 10 clks; first pulse 10 clks after en rises.
- GAP_MIN=2, GAP_MASK=0, enemy_active=0 → spawn_pulse=4'b0001 exactly 2 speed_pulses after en. Model enemy_active[0] rising 2 clks later → next spawn is 4'b0010.
- All 4 slots held active, gap expires → FSM stays in PICK with no pulses. Drop enemy_active[2] → spawn_pulse=4'b0100 within 2 clks.
- ENEMIES_PER_WAVE=2, START=10, STEP=4, MIN=4 → after each wave drains: wave=1 gives period 6, wave=2 gives period 4, wave=3 stays at 4.
- en drops during GAP → no spawn pulses, wave and period unchanged. restart pulse → wave=0, period=SPEED_DIV_START.
- Slot spawned but enemy_active never rises (GONE slot) → pending clears after 3 clks; DRAIN completes and the slot is selectable again.
